// File: rtl/fpcvt_pkg.sv
// Shared types and constants for the linear-to-float converter stages:
// field widths, rounding limits and the packed float word layout.
package fpcvt_pkg;

    localparam int EXP_W = 3;
    localparam int SIG_W = 4;

    localparam logic [EXP_W-1:0] EXP_MAX    = 3'd7;
    localparam logic [SIG_W-1:0] SIG_MAX    = 4'd15;
    localparam logic [SIG_W-1:0] SIG_RENORM = 4'b1000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exponent;
        logic [SIG_W-1:0] significand;
    } fp_word_t;

endpackage

// File: rtl/fp_round.sv
// Combinational round-half-up of a float word using its round (fifth) bit,
// with significand carry renormalisation and clamp to the maximum code.
module fp_round
    import fpcvt_pkg::*;
(
    input  fp_word_t word,
    input  logic     fifth_bit,
    output fp_word_t rounded,
    output logic     sat
);

    logic [SIG_W:0] sig_sum;
    logic [EXP_W:0] exp_sum;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        rounded = word;
        sat     = 1'b0;
        sig_sum = {1'b0, word.significand} + {{SIG_W{1'b0}}, fifth_bit};
        // Significand carry bumps the exponent; exponent carry means the result overflowed.
        exp_sum = {1'b0, word.exponent} + {{EXP_W{1'b0}}, sig_sum[SIG_W]};
        if (exp_sum[EXP_W]) begin
            rounded.exponent    = EXP_MAX;
            rounded.significand = SIG_MAX;
            sat                 = 1'b1;
        end else if (sig_sum[SIG_W]) begin
            rounded.exponent    = exp_sum[EXP_W-1:0];
            rounded.significand = SIG_RENORM;
        end else begin
            rounded.significand = sig_sum[SIG_W-1:0];
        end
    end

endmodule

// File: rtl/fp_round_pack.sv
// Two-stage valid/ready pipeline around fp_round delivering the final float code.
// Define FPCVT_SAT_COUNT_EN to add the saturating sat_count event counter port.
module fp_round_pack
    import fpcvt_pkg::*;
#(
    parameter int SAT_CNT_W = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exponent,
    input  logic [SIG_W-1:0] in_significand,
    input  logic             in_fifth_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exponent,
    output logic [SIG_W-1:0] out_significand,
    output logic             out_sat
`ifdef FPCVT_SAT_COUNT_EN
    ,
    output logic [SAT_CNT_W-1:0] sat_count
`endif
);

    logic     a_valid;
    fp_word_t a_word;
    logic     a_fifth;
    fp_word_t b_word;
    fp_word_t rounded_word;
    logic     rounded_sat;
    logic     b_free;
    logic     in_xfer;
    logic     a_to_b;

    // Stage B frees up in the same cycle it drains, so in_ready sees out_ready combinationally.
    assign b_free   = !out_valid || out_ready;
    assign in_ready = !a_valid || b_free;
    assign in_xfer  = in_valid && in_ready;
    assign a_to_b   = a_valid && b_free;

    fp_round u_round (
        .word      (a_word),
        .fifth_bit (a_fifth),
        .rounded   (rounded_word),
        .sat       (rounded_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            a_valid <= 1'b0;
            a_word  <= '0;
            a_fifth <= 1'b0;
        end else if (in_xfer) begin
            a_valid <= 1'b1;
            a_word  <= '{sign: in_sign, exponent: in_exponent, significand: in_significand};
            a_fifth <= in_fifth_bit;
        end else if (a_to_b) begin
            a_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            b_word    <= '0;
            out_sat   <= 1'b0;
        end else if (a_to_b) begin
            out_valid <= 1'b1;
            b_word    <= rounded_word;
            out_sat   <= rounded_sat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_sign        = b_word.sign;
    assign out_exponent    = b_word.exponent;
    assign out_significand = b_word.significand;

`ifdef FPCVT_SAT_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && out_sat && (sat_count != {SAT_CNT_W{1'b1}})) begin
            sat_count <= sat_count + SAT_CNT_W'(1);
        end
    end
`endif

endmodule
